// File: rtl/scan_mux_n_if.sv
// -----------------------------------------------------------------------------
// scan_mux_n_if
//   Bundles the channel data, select/control and registered result signals of
//   the scanning multiplexer so they can be passed as a single port.
//
//   Parameters
//     N_CH   number of input channels
//     W      bits per channel
//
//   Signals
//     in_bus     N_CH*W  channel k occupies in_bus[k*W +: W]
//     sel        SEL_W   manual channel select
//     mode       1       0 = manual, 1 = scan
//     en         1       1 = run, 0 = pause
//     out        W       registered selected channel data
//     out_ch     SEL_W   channel index that produced out
//     out_valid  1       out/out_ch hold valid data this cycle
//     wrap       1       one-cycle pulse when the scan wraps back to channel 0
//
//   Modports
//     master  drives data and control, observes the result (user side)
//     slave   the multiplexer itself
// -----------------------------------------------------------------------------
interface scan_mux_n_if #(
   parameter int N_CH = 8,
   parameter int W    = 1
);
   localparam int SEL_W = $clog2(N_CH);

   logic [N_CH*W-1:0] in_bus;
   logic [SEL_W-1:0]  sel;
   logic              mode;
   logic              en;
   logic [W-1:0]      out;
   logic [SEL_W-1:0]  out_ch;
   logic              out_valid;
   logic              wrap;

   modport master (
      output in_bus, sel, mode, en,
      input  out, out_ch, out_valid, wrap
   );

   modport slave (
      input  in_bus, sel, mode, en,
      output out, out_ch, out_valid, wrap
   );
endinterface

// File: rtl/scan_mux_n.sv
// -----------------------------------------------------------------------------
// scan_mux_n
//   N-channel, W-bit multiplexer with a registered output. The channel is
//   picked either by the sel input (manual mode) or by an internal round-robin
//   scanner that holds each channel for DWELL cycles (scan mode). Used to
//   sample or display several channels over a single output path.
//
//   Parameters
//     N_CH   number of channels (>= 2, need not be a power of two)
//     W      bits per channel
//     DWELL  cycles each channel is shown in scan mode (>= 1)
//
//   Ports
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    scan_mux_n_if slave modport (data, control and results)
// -----------------------------------------------------------------------------
module scan_mux_n #(
   parameter int N_CH  = 8,
   parameter int W     = 1,
   parameter int DWELL = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   scan_mux_n_if.slave  bus
);
   localparam int SEL_W = $clog2(N_CH);
   localparam int DC_W  = (DWELL > 1) ? $clog2(DWELL) : 1;

   localparam logic [SEL_W-1:0] PTR_LAST   = SEL_W'(N_CH - 1);
   localparam logic [DC_W-1:0]  DWELL_LAST = DC_W'(DWELL - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      MANUAL = 2'd1,
      SCAN   = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [SEL_W-1:0] ptr_q, ptr_d;
   logic [DC_W-1:0]  dwell_q, dwell_d;
   logic [W-1:0]     out_q, out_d;
   logic [SEL_W-1:0] out_ch_q, out_ch_d;
   logic             out_valid_q, out_valid_d;
   logic             wrap_q, wrap_d;

   logic [W-1:0]     man_data;
   logic             man_hit;
   logic [W-1:0]     scan_data;

   // Channel selection for both sources. Comparing against every legal index
   // (rather than indexing in_bus with sel) keeps out-of-range selects from
   // reading past the bus: they simply leave man_hit low and man_data zero.
   always_comb begin
      man_data  = '0;
      man_hit   = 1'b0;
      scan_data = '0;
      for (int k = 0; k < N_CH; k++) begin
         if (bus.sel == SEL_W'(k)) begin
            man_data = bus.in_bus[k*W +: W];
            man_hit  = 1'b1;
         end
         if (ptr_q == SEL_W'(k)) begin
            scan_data = bus.in_bus[k*W +: W];
         end
      end
   end

   // The operating state is decided afresh each cycle from en and mode, so a
   // mode change acts on the very next edge.
   always_comb begin
      if (!bus.en) begin
         state_d = IDLE;
      end else if (bus.mode) begin
         state_d = SCAN;
      end else begin
         state_d = MANUAL;
      end
   end

   // Next-value logic for the outputs and the scanner. In scan mode a wrap is
   // recognised as "ptr=0 with a fresh dwell while already scanning on the
   // previous edge": the only way to get there is the N_CH-1 -> 0 advance, so
   // entering scan at ptr=0 from manual or idle never pulses wrap.
   always_comb begin
      out_d       = out_q;
      out_ch_d    = out_ch_q;
      out_valid_d = 1'b0;
      wrap_d      = 1'b0;
      ptr_d       = ptr_q;
      dwell_d     = dwell_q;
      case (state_d)
         MANUAL: begin
            out_d       = man_data;
            out_ch_d    = bus.sel;
            out_valid_d = man_hit;
            dwell_d     = '0;
         end
         SCAN: begin
            out_d       = scan_data;
            out_ch_d    = ptr_q;
            out_valid_d = 1'b1;
            wrap_d      = (state_q == SCAN) && (ptr_q == '0) && (dwell_q == '0);
            if (dwell_q == DWELL_LAST) begin
               dwell_d = '0;
               ptr_d   = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
            end else begin
               dwell_d = dwell_q + 1'b1;
            end
         end
         default: begin
         end
      endcase
   end

   // All state and registered outputs; reset clears everything at once so an
   // interrupted scan leaves nothing behind.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         dwell_q     <= '0;
         out_q       <= '0;
         out_ch_q    <= '0;
         out_valid_q <= 1'b0;
         wrap_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         dwell_q     <= dwell_d;
         out_q       <= out_d;
         out_ch_q    <= out_ch_d;
         out_valid_q <= out_valid_d;
         wrap_q      <= wrap_d;
      end
   end

   assign bus.out       = out_q;
   assign bus.out_ch    = out_ch_q;
   assign bus.out_valid = out_valid_q;
   assign bus.wrap      = wrap_q;

endmodule
